// File: rtl/wave_sequencer.sv
// rtl/wave_sequencer.sv - sawtooth generator sequencer with shadow/active config and period counting
module wave_sequencer #(
  parameter int DW = 16,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [DW-1:0] cfg_amplitude,
  input  logic [DW-1:0] cfg_prescaler,
  input  logic [CW-1:0] cfg_periods,
  input  logic          start,
  input  logic          stop,
  input  logic [DW-1:0] gen_data,
  output logic          gen_ena,
  output logic [DW-1:0] gen_amplitude,
  output logic [DW-1:0] gen_prescaler,
  output logic          busy,
  output logic          done,
  output logic          cfg_err
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state_q, state_d;
  logic          shadow_full_q, shadow_full_d;
  logic [DW-1:0] shadow_amp_q, shadow_amp_d;
  logic [DW-1:0] shadow_presc_q, shadow_presc_d;
  logic [CW-1:0] shadow_per_q, shadow_per_d;
  logic [DW-1:0] gen_amplitude_q, gen_amplitude_d;
  logic [DW-1:0] gen_prescaler_q, gen_prescaler_d;
  logic [CW-1:0] active_per_q, active_per_d;
  logic          active_valid_q, active_valid_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] prev_data_q, prev_data_d;
  logic          gen_ena_q, gen_ena_d;
  logic          cfg_ready_q, cfg_ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          cfg_err_q, cfg_err_d;
  logic          wrap, accept, load_shadow, end_run;

  always_comb begin
    state_d         = state_q;
    shadow_full_d   = shadow_full_q;
    shadow_amp_d    = shadow_amp_q;
    shadow_presc_d  = shadow_presc_q;
    shadow_per_d    = shadow_per_q;
    gen_amplitude_d = gen_amplitude_q;
    gen_prescaler_d = gen_prescaler_q;
    active_per_d    = active_per_q;
    active_valid_d  = active_valid_q;
    cnt_d           = cnt_q;
    gen_ena_d       = gen_ena_q;
    done_d          = 1'b0;
    cfg_err_d       = 1'b0;
    load_shadow     = 1'b0;
    end_run         = 1'b0;
    // Cleared while disabled so a stale sample cannot fake a wrap on the first run cycle
    prev_data_d     = gen_ena_q ? gen_data : '0;
    wrap            = gen_ena_q && (prev_data_q == gen_amplitude_q) && (gen_data == '0);
    accept          = cfg_valid && cfg_ready_q;

    if (accept) begin
      if (cfg_amplitude == '0) begin
        cfg_err_d = 1'b1;
      end else begin
        shadow_full_d  = 1'b1;
        shadow_amp_d   = cfg_amplitude;
        shadow_presc_d = cfg_prescaler;
        shadow_per_d   = cfg_periods;
      end
    end

    case (state_q)
      IDLE: begin
        if (start && !stop && (shadow_full_q || active_valid_q)) begin
          state_d   = RUN;
          gen_ena_d = 1'b1;
          if (shadow_full_q) load_shadow = 1'b1;
          else               cnt_d = active_per_q;
        end
      end
      RUN: begin
        if (wrap) begin
          if (stop) begin
            end_run = 1'b1;
          end else if (shadow_full_q) begin
            load_shadow = 1'b1;
          end else if (active_per_q != '0) begin
            if (cnt_q <= CW'(1)) end_run = 1'b1;
            else                 cnt_d = cnt_q - CW'(1);
          end
        end else if (stop) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (wrap) end_run = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (load_shadow) begin
      gen_amplitude_d = shadow_amp_q;
      gen_prescaler_d = shadow_presc_q;
      active_per_d    = shadow_per_q;
      cnt_d           = shadow_per_q;
      active_valid_d  = 1'b1;
      shadow_full_d   = 1'b0;
    end
    if (end_run) begin
      state_d   = IDLE;
      gen_ena_d = 1'b0;
      done_d    = 1'b1;
      cnt_d     = '0;
    end

    cfg_ready_d = !shadow_full_d;
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      shadow_full_q   <= 1'b0;
      shadow_amp_q    <= '0;
      shadow_presc_q  <= '0;
      shadow_per_q    <= '0;
      gen_amplitude_q <= '0;
      gen_prescaler_q <= '0;
      active_per_q    <= '0;
      active_valid_q  <= 1'b0;
      cnt_q           <= '0;
      prev_data_q     <= '0;
      gen_ena_q       <= 1'b0;
      cfg_ready_q     <= 1'b1;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      cfg_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      shadow_full_q   <= shadow_full_d;
      shadow_amp_q    <= shadow_amp_d;
      shadow_presc_q  <= shadow_presc_d;
      shadow_per_q    <= shadow_per_d;
      gen_amplitude_q <= gen_amplitude_d;
      gen_prescaler_q <= gen_prescaler_d;
      active_per_q    <= active_per_d;
      active_valid_q  <= active_valid_d;
      cnt_q           <= cnt_d;
      prev_data_q     <= prev_data_d;
      gen_ena_q       <= gen_ena_d;
      cfg_ready_q     <= cfg_ready_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      cfg_err_q       <= cfg_err_d;
    end
  end

  assign cfg_ready     = cfg_ready_q;
  assign gen_ena       = gen_ena_q;
  assign gen_amplitude = gen_amplitude_q;
  assign gen_prescaler = gen_prescaler_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign cfg_err       = cfg_err_q;

endmodule

// File: tb/tb_wave_sequencer.sv
// tb/tb_wave_sequencer.sv - directed self-checking bench for wave_sequencer
module tb_wave_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_amplitude;
  logic [15:0] cfg_prescaler;
  logic [7:0]  cfg_periods;
  logic        start;
  logic        stop;
  logic [15:0] gen_data;
  logic        gen_ena;
  logic [15:0] gen_amplitude;
  logic [15:0] gen_prescaler;
  logic        busy;
  logic        done;
  logic        cfg_err;

  int checks = 0;
  int failures = 0;

  wave_sequencer #(.DW(16), .CW(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_amplitude (cfg_amplitude),
    .cfg_prescaler (cfg_prescaler),
    .cfg_periods   (cfg_periods),
    .start         (start),
    .stop          (stop),
    .gen_data      (gen_data),
    .gen_ena       (gen_ena),
    .gen_amplitude (gen_amplitude),
    .gen_prescaler (gen_prescaler),
    .busy          (busy),
    .done          (done),
    .cfg_err       (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cfg(input logic [15:0] amp, input logic [15:0] presc, input logic [7:0] per);
    cfg_valid     = 1'b1;
    cfg_amplitude = amp;
    cfg_prescaler = presc;
    cfg_periods   = per;
    tick();
    cfg_valid     = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // One full sawtooth period 1..amp then 0; returns just after the wrap edge
  task automatic run_saw(input int amp);
    for (int v = 1; v <= amp; v++) begin
      gen_data = 16'(v);
      tick();
    end
    gen_data = '0;
    tick();
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_amplitude = '0; cfg_prescaler = '0;
    cfg_periods = '0; start = 1'b0; stop = 1'b0; gen_data = '0;
    #12;
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_gen_ena", gen_ena, 0);
    chk("rst_gen_amp", gen_amplitude, 0);
    chk("rst_done", done, 0);
    chk("rst_cfg_err", cfg_err, 0);
    rst = 1'b0;
    tick();

    // zero-amplitude config rejected; start with nothing loaded ignored
    send_cfg(16'd0, 16'd1, 8'd1);
    chk("zero_cfg_err", cfg_err, 1);
    chk("zero_cfg_ready", cfg_ready, 1);
    tick();
    chk("zero_cfg_err_once", cfg_err, 0);
    pulse_start();
    chk("zero_start_busy", busy, 0);
    chk("zero_start_ena", gen_ena, 0);

    // two periods of amplitude 3
    send_cfg(16'd3, 16'd0, 8'd2);
    chk("p2_ready_low", cfg_ready, 0);
    pulse_start();
    chk("p2_ena", gen_ena, 1);
    chk("p2_amp", gen_amplitude, 3);
    chk("p2_busy", busy, 1);
    chk("p2_ready_back", cfg_ready, 1);
    run_saw(3);
    chk("p2_wrap1_busy", busy, 1);
    chk("p2_wrap1_done", done, 0);
    run_saw(3);
    chk("p2_done", done, 1);
    chk("p2_ena_off", gen_ena, 0);
    chk("p2_idle", busy, 0);
    tick();
    chk("p2_done_once", done, 0);
    chk("p2_amp_hold", gen_amplitude, 3);

    // continuous amplitude 5, stop mid-period drains to the wrap
    send_cfg(16'd5, 16'd2, 8'd0);
    pulse_start();
    run_saw(5);
    run_saw(5);
    chk("cont_busy", busy, 1);
    chk("cont_no_done", done, 0);
    gen_data = 16'd1; tick();
    gen_data = 16'd2; stop = 1'b1; tick(); stop = 1'b0;
    chk("drain_busy", busy, 1);
    chk("drain_ena", gen_ena, 1);
    gen_data = 16'd3; tick();
    gen_data = 16'd4; tick();
    gen_data = 16'd5; tick();
    chk("drain_ena_late", gen_ena, 1);
    chk("drain_busy_late", busy, 1);
    gen_data = 16'd0; tick();
    chk("drain_done", done, 1);
    chk("drain_ena_off", gen_ena, 0);
    chk("drain_idle", busy, 0);

    // shadow swap at wrap, then stop coinciding with a wrap
    send_cfg(16'd3, 16'd0, 8'd0);
    pulse_start();
    gen_data = 16'd1; tick();
    gen_data = 16'd2;
    send_cfg(16'd7, 16'd9, 8'd0);
    chk("sh_ready_low", cfg_ready, 0);
    chk("sh_amp_old", gen_amplitude, 3);
    gen_data = 16'd3; tick();
    gen_data = 16'd0; tick();
    chk("sh_amp_new", gen_amplitude, 7);
    chk("sh_presc_new", gen_prescaler, 9);
    chk("sh_ready_back", cfg_ready, 1);
    run_saw(7);
    chk("sh_busy", busy, 1);
    for (int v = 1; v <= 7; v++) begin
      gen_data = 16'(v);
      tick();
    end
    gen_data = '0; stop = 1'b1; tick(); stop = 1'b0;
    chk("sw_done", done, 1);
    chk("sw_idle", busy, 0);
    chk("sw_ena_off", gen_ena, 0);
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    chk("ss_busy", busy, 0);
    chk("ss_ena", gen_ena, 0);

    // reset mid-run, then a fresh run
    send_cfg(16'd4, 16'd6, 8'd1);
    pulse_start();
    gen_data = 16'd1; tick();
    gen_data = 16'd2;
    #3;
    rst = 1'b1;
    #1;
    chk("mr_ena", gen_ena, 0);
    chk("mr_busy", busy, 0);
    chk("mr_amp", gen_amplitude, 0);
    chk("mr_presc", gen_prescaler, 0);
    chk("mr_ready", cfg_ready, 1);
    chk("mr_done", done, 0);
    tick();
    rst = 1'b0;
    gen_data = '0;
    tick();
    chk("mr_post_done", done, 0);
    send_cfg(16'd2, 16'd1, 8'd1);
    pulse_start();
    chk("mr_run_ena", gen_ena, 1);
    chk("mr_run_amp", gen_amplitude, 2);
    run_saw(2);
    chk("mr_run_done", done, 1);
    chk("mr_run_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wave_sequencer.md
WAVE_SEQUENCER -- requirements
Module: wave_sequencer

Interface
REQ-001 Parameter DW, default 16: width of amplitude, prescaler and generator sample.
REQ-002 Parameter CW, default 8: width of period-count field; 0 means run continuously.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 cfg_valid  input  1  config word offered.
REQ-006 cfg_ready  output  1  shadow register empty; config is accepted on cfg_valid && cfg_ready.
REQ-007 cfg_amplitude  input  DW  peak sample value for the offered config.
REQ-008 cfg_prescaler  input  DW  generator clock divider for the offered config.
REQ-009 cfg_periods  input  CW  number of waveform periods to run; 0 means continuous.
REQ-010 start  input  1  one-cycle request to begin generation.
REQ-011 stop  input  1  one-cycle request to end generation at the next period boundary.
REQ-012 gen_data  input  DW  sample fed back from the sawtooth generator.
REQ-013 gen_ena  output  1  generator enable.
REQ-014 gen_amplitude  output  DW  active amplitude driven to the generator.
REQ-015 gen_prescaler  output  DW  active prescaler driven to the generator.
REQ-016 busy  output  1  high whenever state is not IDLE.
REQ-017 done  output  1  one-cycle pulse when a run ends.
REQ-018 cfg_err  output  1  one-cycle pulse when a config is rejected.

Function
REQ-019 Storage: one shadow config (amplitude, prescaler, periods plus a full flag) and one active config; cfg_ready SHALL equal !shadow_full, registered.
REQ-020 Config accept: a config with cfg_amplitude == 0 SHALL be consumed, not stored, and SHALL pulse cfg_err on the next cycle.
REQ-021 Config accept: any other accepted config SHALL set shadow_full on the next edge.
REQ-022 Wrap event: wrap SHALL be asserted when the previous-cycle gen_data == gen_amplitude and the current gen_data == 0, evaluated only while gen_ena = 1.
REQ-023 States: IDLE, RUN, DRAIN.
REQ-024 IDLE -> RUN on start with at least one valid config: the shadow is loaded into active if shadow_full, and shadow_full is cleared; otherwise the existing active config is kept.
REQ-025 The IDLE -> RUN transition SHALL set gen_ena = 1 on the cycle after start.
REQ-026 start in IDLE with no config ever loaded SHALL be ignored.
REQ-027 RUN, on wrap: if shadow_full, the shadow SHALL be copied to active and the period counter reloaded; the new values SHALL appear on gen_* on the next cycle.
REQ-028 RUN, on wrap with no shadow: the period counter SHALL decrement when active periods != 0.
REQ-029 RUN: when the counter goes from 1 to 0 on a wrap, the block SHALL go to IDLE, clear gen_ena and pulse done.
REQ-030 RUN -> DRAIN on stop; DRAIN -> IDLE on the next wrap, clearing gen_ena and pulsing done.
REQ-031 DRAIN SHALL ignore the shadow.
REQ-032 Simultaneous stop and wrap in RUN: the block SHALL go directly to IDLE with done.
REQ-033 Simultaneous start and stop in IDLE: stop SHALL win and the block SHALL stay in IDLE.
REQ-034 start while busy SHALL be ignored.
REQ-035 The period counter is CW bits, loads from active periods, and SHALL never wrap below 0.
REQ-036 Continuous mode (periods == 0) SHALL end only via stop.
REQ-037 gen_amplitude and gen_prescaler SHALL hold their values in IDLE.

Reset
REQ-038 rst high SHALL immediately force: state = IDLE, gen_ena = 0, gen_amplitude = 0, gen_prescaler = 0, shadow_full = 0, cfg_ready = 1, busy = 0, done = 0, cfg_err = 0, period counter = 0, active-valid flag = 0.
REQ-039 Reset asserted mid-run SHALL drop gen_ena without a done pulse.

Verification
REQ-040 Config amp = 3, presc = 0, periods = 2, then start: gen_ena rises the next cycle; after the 2nd wrap (data 3 -> 0) the block is in IDLE with done = 1 for exactly one cycle.
REQ-041 Config amp = 5, periods = 0, start, then stop mid-period: gen_ena stays high until data 5 -> 0, then drops; busy stays high through DRAIN.
REQ-042 Running amp = 3; load a shadow with amp = 7 mid-period: cfg_ready goes 0; gen_amplitude changes to 7 on the cycle after the next wrap; cfg_ready returns to 1.
REQ-043 Config amp = 0: cfg_err pulses once, cfg_ready stays 1, and a following start is ignored (busy = 0).
REQ-044 stop arrives on the same cycle as a wrap: IDLE plus done on the next cycle; start together with stop in IDLE: no transition.
REQ-045 rst asserted during RUN: all outputs reach their reset values asynchronously, done = 0, and a fresh config plus start after release runs normally.
